encoder_8x3_seq: RTL and testbench

ENCODER_8X3_SEQ -- requirements
Module: encoder_8x3_seq

---
 rtl/encoder_8x3_seq.sv | 92 +++++++++
 tb/tb_encoder_8x3_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 priority encoder: captures requests into a pending vector and
// grants the highest pending line one at a time, handshaking each grant with ack.
module encoder_8x3_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       E,
   input  logic [7:0] D,
   input  logic       ack,
   output logic [2:0] A,
   output logic       V,
   output logic [7:0] P,
   output logic       ovf
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state, state_next;
   logic [2:0] a_next;
   logic       v_next;
   logic [7:0] p_next;
   logic       ovf_next;
   logic [7:0] req;
   logic [7:0] clr;
   logic [7:0] rest;

   function automatic logic [2:0] prio(input logic [7:0] x);
      logic [2:0] r;
      r = '0;
      for (int unsigned i = 0; i < 8; i++)
         if (x[i]) r = 3'(i);
      return r;
   endfunction

   always_comb begin
      req  = E ? D : '0;
      clr  = (V && ack) ? (8'b1 << A) : '0;
      rest = P & ~(8'b1 << A);
      // Clear is applied before set so a same-edge re-request keeps the bit pending.
      p_next   = (P & ~clr) | req;
      ovf_next = ovf | (|(req & P & ~clr));

      state_next = state;
      a_next     = A;
      v_next     = V;
      case (state)
         IDLE: begin
            if (|P) begin
               a_next     = prio(P);
               v_next     = 1'b1;
               state_next = HOLD;
            end else begin
               a_next = '0;
               v_next = 1'b0;
            end
         end
         HOLD: begin
            // Next grant is drawn from requests pending before this edge only.
            if (ack) begin
               if (|rest) begin
                  a_next = prio(rest);
               end else begin
                  a_next     = '0;
                  v_next     = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            a_next     = '0;
            v_next     = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         A     <= '0;
         V     <= 1'b0;
         P     <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         A     <= a_next;
         V     <= v_next;
         P     <= p_next;
         ovf   <= ovf_next;
      end
   end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Scoreboard bench for encoder_8x3_seq: a set-based reference model predicts every
// cycle's outputs, which a monitor compares after each rising edge.
module tb_encoder_8x3_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       E = 1'b0;
   logic [7:0] D = '0;
   logic       ack = 1'b0;
   logic [2:0] A;
   logic       V;
   logic [7:0] P;
   logic       ovf;

   encoder_8x3_seq dut (
      .clk(clk), .rst_n(rst_n), .E(E), .D(D), .ack(ack),
      .A(A), .V(V), .P(P), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] a;
      logic       v;
      logic [7:0] p;
      logic       o;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: set of pending lines plus the current grant (-1 = none).
   bit pend[8];
   int grant;
   bit m_ovf;

   function automatic int highest(input bit s[8], input int skip);
      for (int i = 7; i >= 0; i--)
         if (s[i] && i != skip) return i;
      return -1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) pend[i] = 0;
      grant = -1;
      m_ovf = 0;
   endfunction

   function automatic void model_step(input bit e, input logic [7:0] d, input bit k);
      int cl, ng;
      cl = (grant >= 0 && k) ? grant : -1;
      if (grant < 0)  ng = highest(pend, -1);
      else if (k)     ng = highest(pend, grant);
      else            ng = grant;
      for (int i = 0; i < 8; i++) begin
         bit r;
         r = e && d[i];
         if (r && pend[i] && i != cl) m_ovf = 1;
         if (r)            pend[i] = 1;
         else if (i == cl) pend[i] = 0;
      end
      grant = ng;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.a = (grant >= 0) ? 3'(grant) : 3'd0;
      o.v = (grant >= 0);
      for (int i = 0; i < 8; i++) o.p[i] = pend[i];
      o.o = m_ovf;
      return o;
   endfunction

   task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
   endtask

   task automatic cycle(input bit e, input logic [7:0] d, input bit k);
      @(negedge clk);
      E = e; D = d; ack = k;
      model_step(e, d, k);
      exp_q.push_back(model_obs());
   endtask

   // Monitor: one expected snapshot per edge that the stimulus announced.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            obs_t w;
            w = exp_q.pop_front();
            check("cycle {A,V,P,ovf}", {A, V, P, ovf}, w);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("reset state", {A, V, P, ovf}, 13'd0);
      rst_n = 1'b1;

      // single request, held, then acked
      cycle(1, 8'h20, 0);
      repeat (4) cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);
      // multi-hot drained back-to-back
      cycle(1, 8'b1001_0010, 0);
      cycle(0, 8'h00, 1);
      repeat (4) cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);
      // no pre-emption
      cycle(1, 8'h04, 0);
      cycle(0, 8'h00, 0);
      cycle(1, 8'h80, 0);
      repeat (2) cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);
      // enable gating, ack with nothing granted
      repeat (3) cycle(0, 8'hFF, 1);
      // set-wins with A=3 granted
      cycle(1, 8'h08, 0);
      cycle(0, 8'h00, 0);
      cycle(1, 8'h08, 1);
      repeat (2) cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);
      // overflow: same line requested on two edges
      cycle(1, 8'h08, 0);
      cycle(1, 8'h08, 0);
      repeat (3) cycle(0, 8'h00, 1);

      // asynchronous reset pulse mid-HOLD
      cycle(1, 8'h40, 0);
      cycle(0, 8'h00, 0);
      @(negedge clk);
      E = 0; D = '0; ack = 0;
      #1 rst_n = 1'b0;
      #1 check("async reset mid-HOLD", {A, V, P, ovf}, 13'd0);
      #1 rst_n = 1'b1;
      model_reset();
      model_step(0, 8'h00, 0);
      exp_q.push_back(model_obs());

      // one-hot sweep
      for (int i = 0; i < 8; i++) begin
         logic [7:0] oh;
         oh = 8'h01 << i;
         cycle(1, oh, 0);
         cycle(0, 8'h00, 0);
         cycle(0, 8'h00, 1);
         cycle(0, 8'h00, 0);
      end

      // random traffic with sparse requests
      for (int n = 0; n < 400; n++) begin
         bit         e, k;
         logic [7:0] d;
         e = ($urandom_range(3, 0) != 0);
         d = 8'($urandom) & 8'($urandom) & 8'($urandom);
         k = ($urandom_range(2, 0) != 0);
         cycle(e, d, k);
      end

      @(posedge clk);
      #2;
      check("scoreboard drained", 13'(exp_q.size()), 13'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
